// File: rtl/if_align_buf_pkg.sv
// Shared instruction-fetch alignment definitions: FSM state type, FIFO depth,
// and a helper that classifies a halfword as a 16-bit (compressed) instruction.
// No ports; imported by if_align_buf.
package if_align_buf_pkg;

  localparam int IF_ALIGN_DEPTH = 4;
  localparam int IF_ALIGN_PTR_W = 2;
  localparam int IF_ALIGN_CNT_W = 3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SKIP = 1'b1
  } type_if_align_state_e;

  // A halfword starts a 32-bit instruction only when its low two bits are 2'b11.
  function automatic logic is_comp(input logic [15:0] hw);
    return (hw[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/if_align_buf.sv
// Fetch alignment buffer: turns 32-bit fetch words into aligned 16/32-bit instructions.
// Latency: a word accepted in cycle N is visible on inst_o in cycle N+1 (no bypass).
// Backpressure: word_ready_o drops when fewer than two halfword slots are free or on flush;
//   inst_valid_o/inst_o are held stable while inst_ready_i is low.
// Ports: clk, rst_n (async active-low); word_valid_i/word_ready_o/word_i (fetch side);
//   flush_i/flush_pc_i (redirect); inst_valid_o/inst_ready_i/inst_o/inst_pc_o/inst_comp_o (decode side).
module if_align_buf
  import if_align_buf_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic [31:0] word_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_comp_o
);

  logic [15:0]               r_fifo [IF_ALIGN_DEPTH];
  logic [IF_ALIGN_PTR_W-1:0] r_head;
  logic [IF_ALIGN_CNT_W-1:0] r_count;
  logic [31:0]               r_pc;
  type_if_align_state_e      r_state;

  type_if_align_state_e      w_state_nxt;
  logic [15:0]               w_h0;
  logic [15:0]               w_h1;
  logic                      w_comp;
  logic                      w_inst_valid;
  logic                      w_push;
  logic                      w_pop;
  logic [IF_ALIGN_CNT_W-1:0] w_push_n;
  logic [IF_ALIGN_CNT_W-1:0] w_pop_n;
  logic [IF_ALIGN_PTR_W-1:0] w_tail;
  logic [IF_ALIGN_PTR_W-1:0] w_tail_p1;

  // Head decode and handshakes
  always_comb begin
    w_h0         = r_fifo[r_head];
    w_h1         = r_fifo[r_head + 2'd1];
    w_comp       = is_comp(w_h0);
    // A 32-bit instruction needs both halves buffered; a 16-bit one needs only the head.
    w_inst_valid = ((r_count >= 3'd1) && w_comp) || (r_count >= 3'd2);
    word_ready_o = (r_count <= 3'd2) && !flush_i;
    w_push       = word_valid_i && word_ready_o;
    w_pop        = w_inst_valid && inst_ready_i;

    w_pop_n = '0;
    if (w_pop) begin
      w_pop_n = w_comp ? 3'd1 : 3'd2;
    end

    w_push_n = '0;
    if (w_push) begin
      w_push_n = (r_state == ST_SKIP) ? 3'd1 : 3'd2;
    end

    // Pushes only happen with count <= 2, so count[1:0] is the true offset here.
    w_tail    = r_head + r_count[IF_ALIGN_PTR_W-1:0];
    w_tail_p1 = w_tail + 2'd1;
  end

  // Outputs are purely a function of registered state; zeroed when nothing is issuable.
  always_comb begin
    inst_valid_o = w_inst_valid;
    inst_comp_o  = (r_count >= 3'd1) && w_comp;
    inst_pc_o    = r_pc;
    inst_o       = '0;
    if (w_inst_valid) begin
      inst_o = w_comp ? {16'h0000, w_h0} : {w_h1, w_h0};
    end
  end

  // FSM: ST_SKIP drops the low halfword of the first word after a redirect to an odd-halfword PC.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = flush_pc_i[1] ? ST_SKIP : ST_RUN;
    end else if ((r_state == ST_SKIP) && w_push) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointers, occupancy and PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_count <= '0;
      r_pc    <= RESET_PC;
    end else if (flush_i) begin
      r_count <= '0;
      r_pc    <= {flush_pc_i[31:1], 1'b0};
    end else begin
      r_count <= r_count + w_push_n - w_pop_n;
      r_head  <= r_head + w_pop_n[IF_ALIGN_PTR_W-1:0];
      r_pc    <= r_pc + {28'd0, w_pop_n, 1'b0};
    end
  end

  // Halfword storage; writes land at the tail and never overlap live entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IF_ALIGN_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else if (w_push && !flush_i) begin
      if (r_state == ST_SKIP) begin
        r_fifo[w_tail] <= word_i[31:16];
      end else begin
        r_fifo[w_tail]    <= word_i[15:0];
        r_fifo[w_tail_p1] <= word_i[31:16];
      end
    end
  end

endmodule

// File: tb/tb_if_align_buf.sv
module tb_if_align_buf;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [31:0] word_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_comp_o;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a plain queue of pending halfwords plus the PC of the head.
  logic [15:0] mq[$];
  logic [31:0] mpc;
  bit          mskip;

  if_align_buf #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .word_i(word_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_comp_o(inst_comp_o)
  );

  always #5 clk = ~clk;

  function automatic bit m_comp();
    return (mq.size() >= 1) && (mq[0][1:0] != 2'b11);
  endfunction

  function automatic bit m_valid();
    return m_comp() || (mq.size() >= 2);
  endfunction

  function automatic logic [31:0] m_inst();
    if (!m_valid()) return 32'h0;
    if (m_comp()) return {16'h0000, mq[0]};
    return {mq[1], mq[0]};
  endfunction

  // One clock edge; the model applies the handshakes implied by the inputs held across it.
  task automatic cycle();
    bit          v, pr, wv, fl, ir;
    logic [31:0] w, fpc;
    v  = m_valid();
    pr = (mq.size() <= 2) && !flush_i;
    wv = word_valid_i; fl = flush_i; ir = inst_ready_i; w = word_i; fpc = flush_pc_i;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mpc   = {fpc[31:1], 1'b0};
      mskip = fpc[1];
    end else begin
      if (v && ir) begin
        if (m_comp()) begin
          void'(mq.pop_front()); mpc += 2;
        end else begin
          void'(mq.pop_front()); void'(mq.pop_front()); mpc += 4;
        end
      end
      if (wv && pr) begin
        if (mskip) begin
          mq.push_back(w[31:16]); mskip = 0;
        end else begin
          mq.push_back(w[15:0]); mq.push_back(w[31:16]);
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    word_valid_i = 0; word_i = 0; flush_i = 0; flush_pc_i = 0; inst_ready_i = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    mq.delete(); mpc = RST_PC; mskip = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", inst_valid_o); else n_pass++;
    n_total++; if (inst_o !== 32'h0) $display("FAIL rst_inst got %h want 0", inst_o); else n_pass++;
    n_total++; if (inst_comp_o !== 1'b0) $display("FAIL rst_comp got %0b want 0", inst_comp_o); else n_pass++;
    n_total++; if (inst_pc_o !== RST_PC) $display("FAIL rst_pc got %h want %h", inst_pc_o, RST_PC); else n_pass++;
    apply_reset();
    n_total++; if (word_ready_o !== 1'b1) $display("FAIL rst_ready got %0b want 1", word_ready_o); else n_pass++;
  endtask

  task automatic test_full_word();
    apply_reset();
    word_valid_i = 1; word_i = 32'h00A0_0513;
    cycle();
    word_valid_i = 0; #1;
    n_total++; if (inst_valid_o !== 1'b1) $display("FAIL w32_valid got %0b want 1", inst_valid_o); else n_pass++;
    n_total++; if (inst_comp_o !== 1'b0) $display("FAIL w32_comp got %0b want 0", inst_comp_o); else n_pass++;
    n_total++; if (inst_o !== 32'h00A0_0513) $display("FAIL w32_inst got %h want 00a00513", inst_o); else n_pass++;
    n_total++; if (inst_pc_o !== 32'h8000_0000) $display("FAIL w32_pc got %h want 80000000", inst_pc_o); else n_pass++;
  endtask

  task automatic test_two_comp();
    apply_reset();
    word_valid_i = 1; word_i = 32'h4501_4505;
    cycle();
    word_valid_i = 0; inst_ready_i = 1; #1;
    n_total++; if (inst_o !== 32'h0000_4505 || inst_comp_o !== 1'b1 || inst_pc_o !== 32'h8000_0000)
      $display("FAIL c16_first got %h/%0b@%h want 00004505/1@80000000", inst_o, inst_comp_o, inst_pc_o); else n_pass++;
    cycle();
    n_total++; if (inst_o !== 32'h0000_4501 || inst_comp_o !== 1'b1 || inst_pc_o !== 32'h8000_0002)
      $display("FAIL c16_second got %h/%0b@%h want 00004501/1@80000002", inst_o, inst_comp_o, inst_pc_o); else n_pass++;
    cycle();
    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL c16_empty got %0b want 0", inst_valid_o); else n_pass++;
  endtask

  task automatic test_straddle();
    apply_reset();
    word_valid_i = 1; word_i = 32'h0513_4505; inst_ready_i = 1;
    cycle();
    word_valid_i = 0; #1;
    n_total++; if (inst_o !== 32'h0000_4505 || inst_pc_o !== 32'h8000_0000)
      $display("FAIL strad_first got %h@%h want 00004505@80000000", inst_o, inst_pc_o); else n_pass++;
    cycle();
    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL strad_stall got %0b want 0", inst_valid_o); else n_pass++;
    cycle();
    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL strad_stall2 got %0b want 0", inst_valid_o); else n_pass++;
    word_valid_i = 1; word_i = 32'hABCD_00A0; inst_ready_i = 0;
    cycle();
    word_valid_i = 0; #1;
    n_total++; if (inst_valid_o !== 1'b1 || inst_comp_o !== 1'b0 || inst_o !== 32'h00A0_0513 || inst_pc_o !== 32'h8000_0002)
      $display("FAIL strad_join got %0b/%0b/%h@%h want 1/0/00a00513@80000002", inst_valid_o, inst_comp_o, inst_o, inst_pc_o); else n_pass++;
  endtask

  task automatic test_flush_skip();
    apply_reset();
    word_valid_i = 1; word_i = 32'h1111_2222;
    cycle();
    flush_i = 1; flush_pc_i = 32'h8000_0102; word_i = 32'h3333_4444; #1;
    n_total++; if (word_ready_o !== 1'b0) $display("FAIL flush_ready got %0b want 0", word_ready_o); else n_pass++;
    cycle();
    flush_i = 0; word_valid_i = 0; #1;
    n_total++; if (inst_valid_o !== 1'b0 || inst_pc_o !== 32'h8000_0102)
      $display("FAIL flush_after got %0b@%h want 0@80000102", inst_valid_o, inst_pc_o); else n_pass++;
    word_valid_i = 1; word_i = 32'h4585_0001;
    cycle();
    word_valid_i = 0; inst_ready_i = 1; #1;
    n_total++; if (inst_o !== 32'h0000_4585 || inst_comp_o !== 1'b1 || inst_pc_o !== 32'h8000_0102)
      $display("FAIL skip_first got %h/%0b@%h want 00004585/1@80000102", inst_o, inst_comp_o, inst_pc_o); else n_pass++;
    cycle();
    n_total++; if (inst_valid_o !== 1'b0 || inst_pc_o !== 32'h8000_0104)
      $display("FAIL skip_drop got %0b@%h want 0@80000104", inst_valid_o, inst_pc_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    word_valid_i = 1; word_i = 32'h00A0_0513;
    cycle();
    word_i = 32'h4501_4505;
    cycle();
    word_i = 32'hDEAD_BEEF; #1;
    n_total++; if (word_ready_o !== 1'b0 || inst_o !== 32'h00A0_0513)
      $display("FAIL bp_full got %0b/%h want 0/00a00513", word_ready_o, inst_o); else n_pass++;
    cycle();
    n_total++; if (word_ready_o !== 1'b0 || inst_o !== 32'h00A0_0513 || inst_pc_o !== RST_PC)
      $display("FAIL bp_hold got %0b/%h@%h want 0/00a00513@80000000", word_ready_o, inst_o, inst_pc_o); else n_pass++;
    word_valid_i = 0; inst_ready_i = 1;
    cycle();
    n_total++; if (inst_o !== 32'h0000_4505 || inst_pc_o !== 32'h8000_0004)
      $display("FAIL bp_drain1 got %h@%h want 00004505@80000004", inst_o, inst_pc_o); else n_pass++;
    cycle();
    n_total++; if (inst_o !== 32'h0000_4501 || inst_pc_o !== 32'h8000_0006)
      $display("FAIL bp_drain2 got %h@%h want 00004501@80000006", inst_o, inst_pc_o); else n_pass++;
    cycle();
    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL bp_empty got %0b want 0", inst_valid_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    word_valid_i = 1; word_i = 32'h4501_4505;
    cycle();
    word_i = 32'h4509_4507; inst_ready_i = 1;
    cycle();
    idle_inputs(); #1;
    n_total++; if (inst_o !== 32'h0000_4501) $display("FAIL mid_pre got %h want 00004501", inst_o); else n_pass++;
    rst_n = 0; #1;
    n_total++; if (inst_valid_o !== 1'b0) $display("FAIL mid_rst_valid got %0b want 0", inst_valid_o); else n_pass++;
    apply_reset();
    n_total++; if (inst_pc_o !== RST_PC || inst_valid_o !== 1'b0 || word_ready_o !== 1'b1)
      $display("FAIL mid_release got %h/%0b/%0b want 80000000/0/1", inst_pc_o, inst_valid_o, word_ready_o); else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      word_valid_i = ($urandom_range(0, 9) < 7);
      word_i       = $urandom;
      inst_ready_i = ($urandom_range(0, 9) < 6);
      flush_i      = ($urandom_range(0, 19) == 0);
      flush_pc_i   = {16'h8000, 16'($urandom)};
      #1;
      n_total++;
      if (inst_valid_o !== m_valid() || word_ready_o !== ((mq.size() <= 2) && !flush_i) ||
          inst_comp_o !== m_comp() || inst_pc_o !== mpc || (m_valid() && inst_o !== m_inst())) begin
        if (bad < 10)
          $display("FAIL rand[%0d] got v%0b r%0b c%0b %h@%h want v%0b c%0b %h@%h", i, inst_valid_o,
                   word_ready_o, inst_comp_o, inst_o, inst_pc_o, m_valid(), m_comp(), m_inst(), mpc);
        bad++;
      end else n_pass++;
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    mpc = RST_PC; mskip = 0;
    test_reset();
    test_full_word();
    test_two_comp();
    test_straddle();
    test_flush_skip();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
